// File: rtl/trb_mem_arbiter.sv
// Trace-buffer memory responder: alternates read/write slots for the Logger and
// lends unused write slots to a host access port.
module trb_mem_arbiter #(
  parameter int unsigned TRB_WIDTH      = 32,
  parameter int unsigned TRB_ADDR_WIDTH = 5,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      CLK_I,
  input  logic                      RST_NI,
  output logic                      RW_TURN_O,
  input  logic                      WRITE_I,
  output logic                      WRITE_ALLOW_O,
  output logic                      READ_ALLOW_O,
  input  logic [TRB_ADDR_WIDTH-1:0] WRITE_PTR_I,
  input  logic [TRB_WIDTH-1:0]      DATA_I,
  input  logic [TRB_ADDR_WIDTH-1:0] READ_PTR_I,
  output logic [TRB_WIDTH-1:0]      DATA_O,
  input  logic                      SOFT_CLR_I,
  input  logic                      HOST_REQ_I,
  input  logic                      HOST_WE_I,
  input  logic [TRB_ADDR_WIDTH-1:0] HOST_ADDR_I,
  input  logic [TRB_WIDTH-1:0]      HOST_DATA_I,
  output logic                      HOST_GNT_O,
  output logic [TRB_WIDTH-1:0]      HOST_DATA_O,
  output logic                      HOST_VALID_O,
  output logic [DROP_CNT_WIDTH-1:0] DROP_CNT_O
);

  localparam int unsigned DEPTH = 2 ** TRB_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SLOT,
    S_RESP
  } host_state_t;

  host_state_t               r_state;
  host_state_t               w_state_d;
  logic                      r_turn;
  logic [TRB_WIDTH-1:0]      r_mem [DEPTH];
  logic [TRB_ADDR_WIDTH-1:0] r_next_wptr;
  logic [TRB_ADDR_WIDTH-1:0] w_next_wptr_d;
  logic [TRB_ADDR_WIDTH-1:0] w_wptr_inc;
  logic                      w_wr_try;
  logic                      w_wr_ok;
  logic                      w_wr_drop;
  logic                      w_host_gnt;

  assign w_wptr_inc = WRITE_PTR_I + TRB_ADDR_WIDTH'(1);
  assign w_wr_try   = r_turn & WRITE_I;
  assign w_wr_ok    = w_wr_try & WRITE_ALLOW_O;
  assign w_wr_drop  = w_wr_try & ~WRITE_ALLOW_O;

  // Host only gets a write slot the Logger leaves untouched; a soft clear cancels it.
  assign w_host_gnt = (r_state == S_WAIT_SLOT) & HOST_REQ_I & r_turn & ~WRITE_I & ~SOFT_CLR_I;

  assign RW_TURN_O    = r_turn;
  assign HOST_GNT_O   = w_host_gnt;
  assign HOST_VALID_O = (r_state == S_RESP);

  always_comb begin
    w_next_wptr_d = r_next_wptr;
    if (SOFT_CLR_I) begin
      w_next_wptr_d = '0;
    end else if (w_wr_ok) begin
      w_next_wptr_d = w_wptr_inc;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:      if (HOST_REQ_I) w_state_d = S_WAIT_SLOT;
      S_WAIT_SLOT: begin
        if (!HOST_REQ_I) begin
          w_state_d = S_IDLE;
        end else if (w_host_gnt) begin
          w_state_d = HOST_WE_I ? S_IDLE : S_RESP;
        end
      end
      S_RESP:      w_state_d = S_IDLE;
      default:     w_state_d = S_IDLE;
    endcase
    if (SOFT_CLR_I) w_state_d = S_IDLE;
  end

  always_ff @(posedge CLK_I) begin
    if (w_wr_ok) begin
      r_mem[WRITE_PTR_I] <= DATA_I;
    end else if (w_host_gnt && HOST_WE_I) begin
      r_mem[HOST_ADDR_I] <= HOST_DATA_I;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state       <= S_IDLE;
      r_turn        <= 1'b0;
      r_next_wptr   <= '0;
      WRITE_ALLOW_O <= 1'b1;
      READ_ALLOW_O  <= 1'b0;
      DATA_O        <= '0;
      HOST_DATA_O   <= '0;
      DROP_CNT_O    <= '0;
    end else begin
      r_state       <= w_state_d;
      r_turn        <= ~r_turn;
      r_next_wptr   <= w_next_wptr_d;
      WRITE_ALLOW_O <= (w_wptr_inc != READ_PTR_I);
      READ_ALLOW_O  <= (READ_PTR_I != w_next_wptr_d);
      if (!r_turn) DATA_O <= r_mem[READ_PTR_I];
      if (w_host_gnt && !HOST_WE_I) HOST_DATA_O <= r_mem[HOST_ADDR_I];
      if (SOFT_CLR_I) begin
        DROP_CNT_O <= '0;
      end else if (w_wr_drop && !(&DROP_CNT_O)) begin
        DROP_CNT_O <= DROP_CNT_O + DROP_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Bench for trb_mem_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of slots, buffer fill and host requests.
module tb_trb_mem_arbiter;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rw_turn, wr_allow, rd_allow, host_gnt, host_valid;
  logic        w, sc, hreq, hwe;
  logic [4:0]  wp, rp, ha;
  logic [31:0] d, hd, data_o, host_data_o;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  trb_mem_arbiter #(
    .TRB_WIDTH(32),
    .TRB_ADDR_WIDTH(5),
    .DROP_CNT_WIDTH(16)
  ) dut (
    .CLK_I(clk), .RST_NI(rst_n), .RW_TURN_O(rw_turn), .WRITE_I(w),
    .WRITE_ALLOW_O(wr_allow), .READ_ALLOW_O(rd_allow), .WRITE_PTR_I(wp),
    .DATA_I(d), .READ_PTR_I(rp), .DATA_O(data_o), .SOFT_CLR_I(sc),
    .HOST_REQ_I(hreq), .HOST_WE_I(hwe), .HOST_ADDR_I(ha), .HOST_DATA_I(hd),
    .HOST_GNT_O(host_gnt), .HOST_DATA_O(host_data_o), .HOST_VALID_O(host_valid),
    .DROP_CNT_O(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  bit [31:0]   m_mem [DEPTH];
  bit          m_known [DEPTH];
  int unsigned m_cycles;
  bit          m_wr_allow, m_rd_allow, m_data_known, m_hdata_known;
  bit [31:0]   m_data, m_hdata;
  int          m_nwp;
  int unsigned m_drop;
  bit          m_wait, m_resp, m_gnt;
  bit          obs_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit write_slot();
    return (m_cycles % 2) == 1;
  endfunction

  task automatic model_reset();
    m_cycles = 0; m_wr_allow = 1; m_rd_allow = 0;
    m_data = 0; m_data_known = 1; m_hdata = 0; m_hdata_known = 1;
    m_nwp = 0; m_drop = 0; m_wait = 0; m_resp = 0; m_gnt = 0;
  endtask

  task automatic model_edge();
    bit ws = write_slot();
    if (!ws) begin
      m_data = m_mem[rp]; m_data_known = m_known[rp];
    end
    if (ws && w) begin
      if (m_wr_allow) begin
        m_mem[wp] = d; m_known[wp] = 1; m_nwp = (int'(wp) + 1) % DEPTH;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (m_gnt) begin
      if (hwe) begin
        m_mem[ha] = hd; m_known[ha] = 1;
      end else begin
        m_hdata = m_mem[ha]; m_hdata_known = m_known[ha];
      end
    end
    if (sc) m_wait = 0;
    else if (m_wait) m_wait = hreq && !m_gnt;
    else if (!m_resp) m_wait = hreq;
    else m_wait = 0;
    m_resp = m_gnt && !hwe;
    if (sc) begin
      m_nwp = 0; m_drop = 0;
    end
    m_wr_allow = ((int'(wp) + 1) % DEPTH) != int'(rp);
    m_rd_allow = int'(rp) != m_nwp;
    m_cycles++;
  endtask

  task automatic check_outputs();
    check("rw_turn", rw_turn, write_slot());
    check("write_allow", wr_allow, m_wr_allow);
    check("read_allow", rd_allow, m_rd_allow);
    check("drop_cnt", drop_cnt, m_drop);
    check("host_valid", host_valid, m_resp);
    if (m_data_known) check("data_o", data_o, m_data);
    if (m_hdata_known) check("host_data_o", host_data_o, m_hdata);
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic tick();
    @(negedge clk);
    m_gnt = m_wait && hreq && write_slot() && !w && !sc;
    obs_gnt = host_gnt;
    check("host_gnt", host_gnt, m_gnt);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic host_txn(input bit we, input logic [4:0] a, input logic [31:0] dat,
                          input int max_cycles);
    bit granted = 0;
    hreq = 1; hwe = we; ha = a; hd = dat;
    for (int i = 0; i < max_cycles && !granted; i++) begin
      tick();
      if (obs_gnt) granted = 1;
    end
    hreq = 0;
    check("host_grant_seen", granted, 1'b1);
  endtask

  task automatic apply_reset_checks();
    check("rst_host_gnt", host_gnt, 1'b0);
    check("rst_data_o", data_o, 32'h0);
    check("rst_host_data", host_data_o, 32'h0);
    check_outputs();
  endtask

  initial begin
    int gnt_cnt;
    bit h_active;
    rst_n = 0; w = 0; sc = 0; hreq = 0; hwe = 0;
    wp = 0; rp = 0; ha = 0; d = 0; hd = 0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 apply_reset_checks();
    #2 rst_n = 1;

    // Idle: slots alternate starting with a read slot, flags stay empty.
    repeat (4) tick();

    // Single Logger write then read-back.
    while (!write_slot()) tick();
    w = 1; wp = 3; rp = 3; d = 32'hA5A5_0001;
    tick();
    w = 0; wp = 4;
    check("read_allow_after_wr", rd_allow, 1'b1);
    tick();
    check("readback_a5a5", data_o, 32'hA5A5_0001);

    // Full buffer: three dropped writes, then a soft clear.
    while (write_slot()) tick();
    wp = 31; rp = 0; w = 1;
    repeat (7) tick();
    check("full_write_allow", wr_allow, 1'b0);
    check("drop_cnt_3", drop_cnt, 16'd3);
    w = 0; sc = 1;
    tick();
    sc = 0;
    check("drop_cnt_cleared", drop_cnt, 16'd0);

    // Host write then host read of the same address.
    wp = 0; rp = 0;
    host_txn(1'b1, 5'd7, 32'h0000_1234, 6);
    tick();
    host_txn(1'b0, 5'd7, 32'h0, 6);
    check("host_valid_pulse", host_valid, 1'b1);
    check("host_read_1234", host_data_o, 32'h0000_1234);
    tick();

    // Logger holding every write slot starves the host.
    wp = 10; rp = 10; w = 1; hreq = 1; hwe = 0; ha = 5'd7;
    gnt_cnt = 0;
    repeat (8) begin
      tick();
      if (obs_gnt) gnt_cnt++;
    end
    check("host_starved", gnt_cnt, 0);
    w = 0;
    host_txn(1'b0, 5'd7, 32'h0, 2);
    tick();

    // Reset while a host request waits for a slot.
    while (!write_slot()) tick();
    w = 1; hreq = 1; hwe = 1; ha = 5'd9; hd = 32'hDEAD_BEEF;
    tick();
    #1 rst_n = 0;
    #1;
    w = 0; hreq = 0;
    model_reset();
    apply_reset_checks();
    #1 rst_n = 1;
    gnt_cnt = 0;
    repeat (6) begin
      tick();
      if (obs_gnt) gnt_cnt++;
    end
    check("no_gnt_after_reset", gnt_cnt, 0);

    // Random Logger and host traffic.
    h_active = 0;
    for (int n = 0; n < 1500; n++) begin
      if (h_active) begin
        if (m_gnt || $urandom_range(0, 39) == 0) begin
          h_active = 0; hreq = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        h_active = 1; hreq = 1; hwe = 1'($urandom_range(0, 1));
        ha = 5'($urandom); hd = $urandom;
      end
      w  = 1'($urandom_range(0, 1));
      rp = 5'($urandom_range(0, 3));
      wp = ($urandom_range(0, 4) == 0) ? rp - 5'd1 : 5'($urandom_range(0, 3));
      d  = $urandom;
      sc = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
